// File: rtl/mac_row_flex_if.sv
`timescale 1ns/1ps
// mac_row_flex_if: west/north inputs and south/east outputs of one MAC row.
// The master drives row inputs and observes results; the slave is the row.
interface mac_row_flex_if #(
   parameter int unsigned bw      = 4,
   parameter int unsigned psum_bw = 16,
   parameter int unsigned col     = 8
);
   logic                     dataflow;
   logic                     mode;
   logic [2*bw-1:0]          in_w;
   logic [2:0]               inst_w;
   logic [psum_bw*col-1:0]   in_n;
   logic [psum_bw*col-1:0]   out_s;
   logic [col-1:0]           valid;
   logic [2*bw-1:0]          out_e;
   logic [2:0]               inst_e;

   modport master (
      output dataflow, mode, in_w, inst_w, in_n,
      input  out_s, valid, out_e, inst_e
   );

   modport slave (
      input  dataflow, mode, in_w, inst_w, in_n,
      output out_s, valid, out_e, inst_e
   );
endinterface

// File: rtl/mac_row_flex.sv
`timescale 1ns/1ps
// mac_row_flex: one row of `col` MAC tiles. Data and instructions move
// west->east one tile per cycle; partial sums/results leave southwards.
// Supports weight-stationary / output-stationary dataflow and a single- or
// dual-lane precision mode.
// Build option: define MAC_ROW_SAT_EN to saturate every psum/accumulator
// addition instead of wrapping modulo 2^psum_bw.
module mac_row_flex #(
   parameter int unsigned bw      = 4,
   parameter int unsigned psum_bw = 16,
   parameter int unsigned col     = 8
) (
   input  logic             clk,
   input  logic             reset,
   mac_row_flex_if.slave    row
);

   localparam int unsigned DW = 2 * bw;
   localparam int unsigned HB = bw / 2;

   typedef logic signed [psum_bw-1:0] psum_t;

   // Unsigned activation times signed weight, evaluated at psum width.
   function automatic psum_t lane_mul(input logic [bw-1:0] act, input logic [bw-1:0] wt);
      psum_t a;
      psum_t w;
      a = psum_t'({{(psum_bw-bw){1'b0}}, act});
      w = psum_t'({{(psum_bw-bw){wt[bw-1]}}, wt});
      return a * w;
   endfunction

   // Zero-extend a half-lane activation to a full lane.
   function automatic logic [bw-1:0] half_act(input logic [HB-1:0] a);
      return {{(bw-HB){1'b0}}, a};
   endfunction

   // Psum / accumulator addition: saturating or wrapping by build option.
   function automatic psum_t psum_add(input psum_t a, input psum_t b);
`ifdef MAC_ROW_SAT_EN
      logic [psum_bw:0] s;
      s = {a[psum_bw-1], a} + {b[psum_bw-1], b};
      if (s[psum_bw] != s[psum_bw-1])
         return s[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}} : {1'b0, {(psum_bw-1){1'b1}}};
      return s[psum_bw-1:0];
`else
      return a + b;
`endif
   endfunction

   logic [DW-1:0]  data_q [col];
   logic [DW-1:0]  data_d [col];
   logic [2:0]     inst_q [col];
   logic [2:0]     inst_d [col];
   logic [bw-1:0]  w0_q   [col];
   logic [bw-1:0]  w0_d   [col];
   logic [bw-1:0]  w1_q   [col];
   logic [bw-1:0]  w1_d   [col];
   psum_t          acc_q  [col];
   psum_t          acc_d  [col];
   psum_t          out_q  [col];
   psum_t          out_d  [col];
   logic [col-1:0] load_done_q, load_done_d;
   logic [col-1:0] vld_q, vld_d;
   logic           ld_in;

   // 011 enters the row as a pure load; a flush suppresses any load bit.
   assign ld_in = row.inst_w[0] & ~row.inst_w[2];

   // West->east pipeline; a load bit only travels past tiles already loaded.
   always_comb begin
      data_d[0] = row.in_w;
      inst_d[0] = {row.inst_w[2], row.inst_w[1] & ~ld_in, ld_in};
      for (int unsigned i = 1; i < col; i++) begin
         data_d[i] = data_q[i-1];
         inst_d[i] = {inst_q[i-1][2:1], inst_q[i-1][0] & load_done_q[i-1]};
      end
   end

   // Per-tile datapath: weight capture, WS psum, OS accumulate/flush.
   always_comb begin
      psum_t         nslice;
      psum_t         prod;
      logic [bw-1:0] op0;
      logic [bw-1:0] op1;
      load_done_d = load_done_q;
      vld_d       = '0;
      for (int unsigned i = 0; i < col; i++) begin
         w0_d[i]  = w0_q[i];
         w1_d[i]  = w1_q[i];
         acc_d[i] = acc_q[i];
         out_d[i] = out_q[i];
         nslice   = row.in_n[i*psum_bw +: psum_bw];
         op0      = row.dataflow ? nslice[bw-1:0] : w0_q[i];
         op1      = row.dataflow ? nslice[DW-1:bw] : w1_q[i];
         prod     = row.mode
                  ? lane_mul(half_act(data_q[i][HB-1:0]), op0)
                    + lane_mul(half_act(data_q[i][bw+HB-1:bw]), op1)
                  : lane_mul(data_q[i][bw-1:0], op0);

         if (inst_q[i][0] && !load_done_q[i]) begin
            w0_d[i]        = data_q[i][bw-1:0];
            w1_d[i]        = data_q[i][DW-1:bw];
            load_done_d[i] = 1'b1;
         end

         if (!row.dataflow) begin
            if (inst_q[i][1]) begin
               out_d[i] = psum_add(nslice, prod);
               vld_d[i] = 1'b1;
            end
            if (inst_q[i][2])
               load_done_d[i] = 1'b0;
         end else if (inst_q[i][2]) begin
            out_d[i] = inst_q[i][1] ? psum_add(acc_q[i], prod) : acc_q[i];
            acc_d[i] = '0;
            vld_d[i] = 1'b1;
         end else if (inst_q[i][1]) begin
            acc_d[i] = psum_add(acc_q[i], prod);
         end
      end
   end

   // State registers; asynchronous active-low reset clears everything.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < col; i++) begin
            data_q[i] <= '0;
            inst_q[i] <= '0;
            w0_q[i]   <= '0;
            w1_q[i]   <= '0;
            acc_q[i]  <= '0;
            out_q[i]  <= '0;
         end
         load_done_q <= '0;
         vld_q       <= '0;
      end else begin
         for (int unsigned i = 0; i < col; i++) begin
            data_q[i] <= data_d[i];
            inst_q[i] <= inst_d[i];
            w0_q[i]   <= w0_d[i];
            w1_q[i]   <= w1_d[i];
            acc_q[i]  <= acc_d[i];
            out_q[i]  <= out_d[i];
         end
         load_done_q <= load_done_d;
         vld_q       <= vld_d;
      end
   end

   // Pack per-tile results onto the south bus.
   always_comb begin
      row.out_s = '0;
      for (int unsigned i = 0; i < col; i++)
         row.out_s[i*psum_bw +: psum_bw] = out_q[i];
   end

   assign row.valid  = vld_q;
   assign row.out_e  = data_q[col-1];
   assign row.inst_e = inst_q[col-1];

endmodule

// File: tb/tb_mac_row_flex.sv
`timescale 1ns/1ps
// tb_mac_row_flex: directed scenarios with literal expectations plus
// randomized traffic, all outputs compared every cycle against a
// transaction-timeline model of the row.
module tb_mac_row_flex;

   localparam int BW  = 4;
   localparam int PB  = 16;
   localparam int COL = 8;
   localparam int DW  = 2 * BW;
   localparam int HB  = BW / 2;
   localparam longint PMAX = (64'sd1 <<< (PB - 1)) - 1;
   localparam longint PMIN = -(64'sd1 <<< (PB - 1));
`ifdef MAC_ROW_SAT_EN
   localparam int OVF_EXP = 32767;
`else
   localparam int OVF_EXP = -32731;
`endif

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   mac_row_flex_if #(.bw(BW), .psum_bw(PB), .col(COL)) bus ();

   mac_row_flex #(.bw(BW), .psum_bw(PB), .col(COL)) dut (
      .clk   (clk),
      .reset (reset),
      .row   (bus)
   );

   task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // tx[k] is the west input captured k edges ago; tile i works on tx[i+1].
   logic [DW-1:0] tx_d    [COL+1];
   logic [2:0]    tx_i    [COL+1];
   int            tx_dest [COL+1];
   int            m_w0 [COL];
   int            m_w1 [COL];
   int            m_acc[COL];
   int            m_out[COL];
   bit            m_vld[COL];
   int            m_claim;

   function automatic int sx(input logic [BW-1:0] w);
      return int'($signed(w));
   endfunction

   function automatic int fit(input longint v);
      longint m;
`ifdef MAC_ROW_SAT_EN
      if (v > PMAX) return int'(PMAX);
      if (v < PMIN) return int'(PMIN);
      return int'(v);
`else
      m = v & ((64'sd1 <<< PB) - 1);
      if (m > PMAX) m = m - (64'sd1 <<< PB);
      return int'(m);
`endif
   endfunction

   task automatic model_clear();
      for (int k = 0; k <= COL; k++) begin
         tx_d[k] = '0; tx_i[k] = '0; tx_dest[k] = COL;
      end
      for (int i = 0; i < COL; i++) begin
         m_w0[i] = 0; m_w1[i] = 0; m_acc[i] = 0; m_out[i] = 0; m_vld[i] = 0;
      end
      m_claim = 0;
   endtask

   task automatic model_step();
      logic [2:0]    raw;
      logic [DW-1:0] d;
      logic [2:0]    ins;
      logic [PB-1:0] nv;
      bit            ld, ex, fl;
      int            dest, o0, o1, prod;
      raw  = bus.inst_w;
      fl   = raw[2];
      ld   = raw[0] && !fl;
      ex   = raw[1] && !ld;
      dest = COL;
      // consecutive load words claim tiles 0,1,2,... until a WS flush
      if (ld) begin
         dest = (m_claim < COL) ? m_claim : COL;
         if (m_claim < COL) m_claim++;
      end
      if (fl && !bus.dataflow) m_claim = 0;
      for (int k = COL; k > 0; k--) begin
         tx_d[k] = tx_d[k-1]; tx_i[k] = tx_i[k-1]; tx_dest[k] = tx_dest[k-1];
      end
      tx_d[0] = bus.in_w; tx_i[0] = {fl, ex, ld}; tx_dest[0] = dest;

      for (int i = 0; i < COL; i++) begin
         d        = tx_d[i+1];
         ins      = tx_i[i+1];
         nv       = bus.in_n[i*PB +: PB];
         m_vld[i] = 1'b0;
         if (ins[0] && i == tx_dest[i+1]) begin
            m_w0[i] = sx(d[BW-1:0]);
            m_w1[i] = sx(d[DW-1:BW]);
         end
         o0 = bus.dataflow ? sx(nv[BW-1:0])  : m_w0[i];
         o1 = bus.dataflow ? sx(nv[DW-1:BW]) : m_w1[i];
         if (bus.mode)
            prod = int'(d[HB-1:0]) * o0 + int'(d[BW+HB-1:BW]) * o1;
         else
            prod = int'(d[BW-1:0]) * o0;
         if (!bus.dataflow) begin
            if (ins[1]) begin
               m_out[i] = fit(longint'(int'($signed(nv))) + prod);
               m_vld[i] = 1'b1;
            end
         end else if (ins[2]) begin
            m_out[i] = ins[1] ? fit(longint'(m_acc[i]) + prod) : m_acc[i];
            m_acc[i] = 0;
            m_vld[i] = 1'b1;
         end else if (ins[1]) begin
            m_acc[i] = fit(longint'(m_acc[i]) + prod);
         end
      end
   endtask

   initial model_clear();

   always @(posedge clk or negedge reset) begin
      if (!reset) model_clear();
      else        model_step();
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      logic [COL-1:0] ev;
      logic [2:0]     ei;
      for (int i = 0; i < COL; i++) begin
         ev[i] = m_vld[i];
         check($sformatf("out_s[%0d]", i), $signed(bus.out_s[i*PB +: PB]), m_out[i]);
      end
      check("valid", bus.valid, ev);
      check("out_e", bus.out_e, tx_d[COL-1]);
      ei = {tx_i[COL-1][2:1], tx_i[COL-1][0] && (COL - 1 <= tx_dest[COL-1])};
      check("inst_e", bus.inst_e, ei);
   end

   // ---------------- stimulus helpers ----------------
   task automatic step(input logic [2:0] ins, input logic [DW-1:0] d);
      @(negedge clk);
      bus.inst_w = ins;
      bus.in_w   = d;
   endtask

   task automatic idle(input int n);
      repeat (n) step(3'b000, '0);
   endtask

   task automatic set_n(input logic [PB-1:0] v);
      for (int i = 0; i < COL; i++) bus.in_n[i*PB +: PB] = v;
   endtask

   task automatic rand_n();
      for (int i = 0; i < COL; i++) bus.in_n[i*PB +: PB] = PB'($urandom);
   endtask

   // Issue one instruction, then read tile i's result after edge E+i+1.
   task automatic issue_and_check(input string tag, input logic [2:0] ins, input logic [DW-1:0] d,
                                  input int exp [COL], input int ntiles);
      step(ins, d);
      step(3'b000, '0);
      for (int i = 0; i < COL; i++) begin
         step(3'b000, '0);
         if (i < ntiles) begin
            check($sformatf("%s out_s[%0d]", tag, i), $signed(bus.out_s[i*PB +: PB]), exp[i]);
            check($sformatf("%s valid[%0d]", tag, i), bus.valid[i], 1);
         end
      end
   endtask

   task automatic check_all_zero(input string tag);
      for (int i = 0; i < COL; i++)
         check($sformatf("%s out_s[%0d]", tag, i), bus.out_s[i*PB +: PB], 0);
      check({tag, " valid"},  bus.valid,  0);
      check({tag, " out_e"},  bus.out_e,  0);
      check({tag, " inst_e"}, bus.inst_e, 0);
   endtask

   function automatic logic [2:0] pick_inst();
      int r;
      r = $urandom_range(0, 9);
      case (r)
         0, 1, 2: return 3'b010;
         3, 4:    return 3'b001;
         5:       return 3'b011;
         6:       return 3'b100;
         7:       return 3'b110;
         default: return 3'b000;
      endcase
   endfunction

   // ---------------- test sequence ----------------
   initial begin
      int e [COL];
      bus.dataflow = 1'b0;
      bus.mode     = 1'b0;
      bus.in_w     = '0;
      bus.inst_w   = '0;
      bus.in_n     = '0;

      // reset state
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      reset = 1'b1;

      // executes in flight, then reset mid-stream
      set_n(16'd7);
      repeat (4) step(3'b010, 8'h05);
      #2 reset = 1'b0;
      #1 check_all_zero("midreset");
      @(negedge clk);
      bus.inst_w = '0;
      bus.in_w   = '0;
      reset      = 1'b1;
      for (int k = 0; k < COL + 3; k++) begin
         step(3'b000, '0);
         check("post-reset valid", bus.valid, 0);
      end

      // WS mode 0: weights i-3, act 3
      set_n('0);
      for (int k = 0; k < COL; k++) step(3'b001, DW'((k - 3) & 15));
      idle(2 * COL);
      for (int i = 0; i < COL; i++) e[i] = 3 * (i - 3);
      issue_and_check("ws_m0", 3'b010, 8'h03, e, COL);

      // reload after flush: weights 1..8 (8 reads as -8 in a 4-bit signed lane)
      step(3'b100, '0);
      idle(2);
      for (int k = 0; k < COL; k++) step(3'b001, DW'(k + 1));
      idle(2 * COL);
      for (int i = 0; i < COL; i++) e[i] = (i == 7) ? -8 : i + 1;
      issue_and_check("reload", 3'b010, 8'h01, e, COL);

      // overflow: 32700 + 15*7
      step(3'b100, '0);
      idle(2);
      for (int k = 0; k < COL; k++) step(3'b001, 8'h07);
      idle(2 * COL);
      set_n(16'd32700);
      for (int i = 0; i < COL; i++) e[i] = OVF_EXP;
      issue_and_check("overflow", 3'b010, 8'h0F, e, COL);

      // WS mode 1: tile 0 w0=-2 w1=3, act0=1 act1=2, in_n=10
      idle(2 * COL + 2);
      bus.mode = 1'b1;
      idle(2);
      step(3'b100, '0);
      idle(2);
      step(3'b001, 8'h3E);
      idle(2 * COL);
      set_n(16'd10);
      e[0] = 14;
      issue_and_check("ws_m1", 3'b010, 8'h21, e, 1);

      // OS mode 0: four executes act 2 operand 5, then two flushes
      idle(2 * COL + 2);
      bus.dataflow = 1'b1;
      bus.mode     = 1'b0;
      idle(2);
      set_n(16'd5);
      repeat (4) step(3'b010, 8'h02);
      for (int i = 0; i < COL; i++) e[i] = 40;
      issue_and_check("os_flush", 3'b100, '0, e, COL);
      for (int i = 0; i < COL; i++) e[i] = 0;
      issue_and_check("os_flush2", 3'b100, '0, e, COL);

      // randomized traffic: WS m0, WS m1, OS m0, OS m1
      for (int r = 0; r < 4; r++) begin
         idle(2 * COL + 2);
         bus.dataflow = (r >= 2);
         bus.mode     = r[0];
         idle(2);
         for (int k = 0; k < 400; k++) begin
            step(pick_inst(), DW'($urandom));
            rand_n();
         end
      end
      idle(2 * COL + 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
